// File: rtl/srt_div_arbiter_pkg.sv
// Shared types and FP32 constants for the two-port SRT divider arbiter.
package srt_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_BYPASS,
    ST_RESP
  } state_e;

  localparam int N_ITER_DEF = 13;

  localparam logic [31:0] FP_NAN      = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_NEG_INF  = 32'hFF80_0000;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;

  function automatic logic [31:0] signed_inf(input logic sign);
    return sign ? FP_NEG_INF : FP_POS_INF;
  endfunction

  function automatic logic [31:0] signed_zero(input logic sign);
    return sign ? FP_NEG_ZERO : FP_POS_ZERO;
  endfunction

endpackage

// File: rtl/srt_div_arbiter_if.sv
// Requester, response and divider-core signals of the divider arbiter.
interface srt_div_arbiter_if #(
  parameter int TAG_W = 2
);
  logic             in0_valid;
  logic             in0_ready;
  logic [31:0]      in0_dividend;
  logic [31:0]      in0_divisor;
  logic [TAG_W-1:0] in0_tag;
  logic             in1_valid;
  logic             in1_ready;
  logic [31:0]      in1_dividend;
  logic [31:0]      in1_divisor;
  logic [TAG_W-1:0] in1_tag;
  logic             core_load;
  logic             core_iter_en;
  logic [31:0]      core_dividend;
  logic [31:0]      core_divisor;
  logic [31:0]      core_quotient;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_quotient;
  logic             resp_port;
  logic [TAG_W-1:0] resp_tag;

  // Environment side: requesters, response consumer and the shared core.
  modport master (
    output in0_valid, in0_dividend, in0_divisor, in0_tag,
    output in1_valid, in1_dividend, in1_divisor, in1_tag,
    input  in0_ready, in1_ready,
    input  core_load, core_iter_en, core_dividend, core_divisor,
    output core_quotient,
    input  resp_valid, resp_quotient, resp_port, resp_tag,
    output resp_ready
  );

  // Arbiter side.
  modport slave (
    input  in0_valid, in0_dividend, in0_divisor, in0_tag,
    input  in1_valid, in1_dividend, in1_divisor, in1_tag,
    output in0_ready, in1_ready,
    output core_load, core_iter_en, core_dividend, core_divisor,
    input  core_quotient,
    output resp_valid, resp_quotient, resp_port, resp_tag,
    input  resp_ready
  );
endinterface

// File: rtl/srt_div_arbiter_special.sv
// Combinational FP32 special-case classifier: flags operand pairs whose
// quotient is fixed (NaN, infinity, zero) and produces that quotient.
module srt_div_special
  import srt_div_pkg::*;
(
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        special,
  output logic [31:0] result
);
  logic a_exp_max, b_exp_max, a_man_zero, b_man_zero;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign;

  assign a_exp_max  = &dividend[30:23];
  assign b_exp_max  = &divisor[30:23];
  assign a_man_zero = ~|dividend[22:0];
  assign b_man_zero = ~|divisor[22:0];
  assign a_zero     = ~|dividend[30:0];
  assign b_zero     = ~|divisor[30:0];
  assign a_inf      = a_exp_max && a_man_zero;
  assign b_inf      = b_exp_max && b_man_zero;
  assign a_nan      = a_exp_max && !a_man_zero;
  assign b_nan      = b_exp_max && !b_man_zero;
  assign sign       = dividend[31] ^ divisor[31];

  // Priority decode: invalid operations first, then infinities, then zeros.
  always_comb begin
    special = 1'b1;
    result  = FP_NAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      result = FP_NAN;
    end else if (b_zero || a_inf) begin
      result = signed_inf(sign);
    end else if (a_zero || b_inf) begin
      result = signed_zero(sign);
    end else begin
      special = 1'b0;
    end
  end
endmodule

// File: rtl/srt_div_arbiter.sv
// Two-requester round-robin front end for a shared radix-4 SRT divider core.
// Special operands bypass the core; one operation is in flight at a time.
module srt_div_arbiter
  import srt_div_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEF,
  parameter int TAG_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  srt_div_arbiter_if.slave bus
);
  localparam logic [3:0] LAST_ITER = 4'(N_ITER - 1);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      dividend_q, dividend_d;
  logic [31:0]      divisor_q, divisor_d;
  logic [31:0]      quot_q, quot_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             port_q, port_d;

  logic        grant, idle, accept;
  logic [31:0] cls_dividend, cls_divisor, special_result;
  logic        special;
  logic        core_load, core_iter_en, resp_valid;

  // A lone requester wins outright; contention is settled by the pointer.
  always_comb begin
    grant = ptr_q;
    if (bus.in0_valid && !bus.in1_valid) begin
      grant = 1'b0;
    end else if (!bus.in0_valid && bus.in1_valid) begin
      grant = 1'b1;
    end
  end

  assign idle          = rst && (state_q == ST_IDLE);
  assign bus.in0_ready = idle && !grant;
  assign bus.in1_ready = idle && grant;
  assign accept        = (bus.in0_ready && bus.in0_valid) || (bus.in1_ready && bus.in1_valid);

  // The classifier sees the incoming operands while idle (to pick the path)
  // and the latched operands afterwards (to produce the bypass result).
  always_comb begin
    cls_dividend = dividend_q;
    cls_divisor  = divisor_q;
    if (state_q == ST_IDLE) begin
      cls_dividend = grant ? bus.in1_dividend : bus.in0_dividend;
      cls_divisor  = grant ? bus.in1_divisor  : bus.in0_divisor;
    end
  end

  srt_div_special u_special (
    .dividend (cls_dividend),
    .divisor  (cls_divisor),
    .special  (special),
    .result   (special_result)
  );

  // Next-state and output decode for the operation sequencer.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    quot_d       = quot_q;
    tag_d        = tag_q;
    port_d       = port_q;
    core_load    = 1'b0;
    core_iter_en = 1'b0;
    resp_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dividend_d = cls_dividend;
          divisor_d  = cls_divisor;
          tag_d      = grant ? bus.in1_tag : bus.in0_tag;
          port_d     = grant;
          ptr_d      = !grant;
          state_d    = special ? ST_BYPASS : ST_LOAD;
        end
      end
      ST_LOAD: begin
        core_load = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ITER;
      end
      ST_ITER: begin
        core_iter_en = 1'b1;
        cnt_d        = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) begin
          quot_d  = bus.core_quotient;
          state_d = ST_RESP;
        end
      end
      ST_BYPASS: begin
        quot_d  = special_result;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      tag_q      <= '0;
      port_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      tag_q      <= tag_d;
      port_q     <= port_d;
    end
  end

  assign bus.core_load     = core_load;
  assign bus.core_iter_en  = core_iter_en;
  assign bus.core_dividend = dividend_q;
  assign bus.core_divisor  = divisor_q;
  assign bus.resp_valid    = resp_valid;
  assign bus.resp_quotient = quot_q;
  assign bus.resp_port     = port_q;
  assign bus.resp_tag      = tag_q;
endmodule

// File: tb/tb_srt_div_arbiter.sv
// Self-checking bench for srt_div_arbiter with a behavioural divider core.
module tb_srt_div_arbiter;
  import srt_div_pkg::*;

  localparam int N_ITER = 13;
  localparam int TAG_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  srt_div_arbiter_if #(.TAG_W(TAG_W)) bus();

  srt_div_arbiter #(.N_ITER(N_ITER), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  tag;
  } op_t;

  int n_vec = 0;
  int n_miss = 0;
  int ncyc = 0;
  int load_total = 0;
  int iter_total = 0;
  int overlap_total = 0;
  int stab_err = 0;
  int iter_in_op = 0;
  bit model_ptr = 1'b0;
  logic [31:0] ld_a, ld_b;

  // Stand-in divider core: a fixed mapping of the operands.
  function automatic logic [31:0] core_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return {a[15:0], b[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // 0 zero, 1 finite nonzero, 2 infinity, 3 NaN
  function automatic int fp_class(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] == 23'd0) ? 2 : 3;
    if (x[30:0] == 31'd0) return 0;
    return 1;
  endfunction

  // {bypass, expected quotient} from IEEE division rules.
  function automatic logic [32:0] ref_result(input logic [31:0] a, input logic [31:0] b);
    int ca, cb;
    logic s;
    ca = fp_class(a);
    cb = fp_class(b);
    s  = a[31] ^ b[31];
    if (ca == 3 || cb == 3 || (ca == 0 && cb == 0) || (ca == 2 && cb == 2)) return {1'b1, 32'h7FC0_0000};
    if (cb == 0 || ca == 2) return {1'b1, s, 8'hFF, 23'd0};
    if (ca == 0 || cb == 2) return {1'b1, s, 31'd0};
    return {1'b0, core_model(a, b)};
  endfunction

  function automatic logic [31:0] rand_operand(input int cls);
    logic s;
    s = 1'($urandom_range(0, 1));
    case (cls)
      0: return {s, 31'd0};
      1: return {s, 8'hFF, 23'd0};
      2: return {s, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // Core model and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    ncyc++;
    if (bus.core_load) begin
      load_total++;
      iter_in_op = 0;
      ld_a = bus.core_dividend;
      ld_b = bus.core_divisor;
    end
    if (bus.core_iter_en) begin
      iter_total++;
      iter_in_op++;
      if (bus.core_dividend !== ld_a || bus.core_divisor !== ld_b) stab_err++;
    end
    if (bus.core_load && bus.core_iter_en) overlap_total++;
    bus.core_quotient = (bus.core_iter_en && iter_in_op == N_ITER) ? core_model(bus.core_dividend, bus.core_divisor) : 32'hDEAD_BEEF;
  end

  // Issues one operation on a port and collects its response.
  task automatic run_op(input bit port, input logic [31:0] a, input logic [31:0] b, input logic [1:0] tag,
                        output int lat, output logic [31:0] q, output bit rport, output logic [1:0] rtag,
                        output int nload, output int niter);
    int t0, l0, i0;
    bit seen;
    lat = -1; q = '0; rport = 1'b0; rtag = '0; nload = 0; niter = 0;
    @(negedge clk);
    if (port) begin
      bus.in1_valid = 1'b1; bus.in1_dividend = a; bus.in1_divisor = b; bus.in1_tag = tag;
    end else begin
      bus.in0_valid = 1'b1; bus.in0_dividend = a; bus.in0_divisor = b; bus.in0_tag = tag;
    end
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (port ? bus.in1_ready : bus.in0_ready) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      n_vec++; n_miss++;
      $display("[TB] FAIL accept_timeout port=%0d: ready never seen, required within 100 cycles", port);
      bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
      return;
    end
    t0 = ncyc; l0 = load_total; i0 = iter_total;
    model_ptr = !port;
    @(negedge clk);
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (bus.resp_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) return;
    lat = ncyc - t0; q = bus.resp_quotient; rport = bus.resp_port; rtag = bus.resp_tag;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    nload = load_total - l0; niter = iter_total - i0;
  endtask

  task automatic test_reset();
    bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
    bus.in0_dividend = '0; bus.in0_divisor = '0; bus.in0_tag = '0;
    bus.in1_dividend = '0; bus.in1_divisor = '0; bus.in1_tag = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL rst_resp_valid got %b want 0", bus.resp_valid); end
    n_vec++; if (bus.core_load !== 1'b0) begin n_miss++; $display("[TB] FAIL rst_core_load got %b want 0", bus.core_load); end
    n_vec++; if (bus.core_iter_en !== 1'b0) begin n_miss++; $display("[TB] FAIL rst_core_iter_en got %b want 0", bus.core_iter_en); end
    n_vec++; if (bus.in0_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL rst_in0_ready got %b want 0", bus.in0_ready); end
    n_vec++; if (bus.in1_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL rst_in1_ready got %b want 0", bus.in1_ready); end
    n_vec++; if (bus.resp_quotient !== 32'd0) begin n_miss++; $display("[TB] FAIL rst_resp_quotient got %h want 0", bus.resp_quotient); end
    n_vec++; if (bus.resp_tag !== 2'd0) begin n_miss++; $display("[TB] FAIL rst_resp_tag got %0d want 0", bus.resp_tag); end
    n_vec++; if (bus.resp_port !== 1'b0) begin n_miss++; $display("[TB] FAIL rst_resp_port got %b want 0", bus.resp_port); end
    rst = 1'b1;
    #1;
    n_vec++; if (bus.in0_ready !== 1'b1 || bus.in1_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL first_ready got %b%b want 10 (in0,in1)", bus.in0_ready, bus.in1_ready); end
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    model_ptr = 1'b0;
  endtask

  task automatic test_basic();
    int lat, nl, ni; logic [31:0] q; bit p; logic [1:0] t;
    run_op(1'b0, 32'h40C0_0000, 32'h4000_0000, 2'd1, lat, q, p, t, nl, ni);
    n_vec++; if (lat != N_ITER + 2) begin n_miss++; $display("[TB] FAIL basic_latency got %0d want %0d", lat, N_ITER + 2); end
    n_vec++; if (q !== 32'h4040_0000) begin n_miss++; $display("[TB] FAIL basic_quotient got %h want 40400000", q); end
    n_vec++; if (p !== 1'b0 || t !== 2'd1) begin n_miss++; $display("[TB] FAIL basic_port_tag got %b/%0d want 0/1", p, t); end
    n_vec++; if (nl != 1) begin n_miss++; $display("[TB] FAIL basic_load_count got %0d want 1", nl); end
    n_vec++; if (ni != N_ITER) begin n_miss++; $display("[TB] FAIL basic_iter_count got %0d want %0d", ni, N_ITER); end
  endtask

  task automatic test_special();
    logic [31:0] tbl_a [3] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
    logic [31:0] tbl_q [3] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000};
    int lat, nl, ni; logic [31:0] q; bit p, port; logic [1:0] t, tag;
    for (int i = 0; i < 3; i++) begin
      port = 1'($urandom_range(0, 1)); tag = 2'($urandom);
      run_op(port, tbl_a[i], 32'h0, tag, lat, q, p, t, nl, ni);
      n_vec++; if (q !== tbl_q[i]) begin n_miss++; $display("[TB] FAIL special%0d_quotient got %h want %h", i, q, tbl_q[i]); end
      n_vec++; if (lat != 2) begin n_miss++; $display("[TB] FAIL special%0d_latency got %0d want 2", i, lat); end
      n_vec++; if (nl != 0 || ni != 0) begin n_miss++; $display("[TB] FAIL special%0d_core_touched load=%0d iter=%0d want 0/0", i, nl, ni); end
      n_vec++; if (p !== port || t !== tag) begin n_miss++; $display("[TB] FAIL special%0d_port_tag got %b/%0d want %b/%0d", i, p, t, port, tag); end
    end
  endtask

  task automatic test_random();
    int lat, nl, ni, want_lat; logic [31:0] q, a, b; bit p, port; logic [1:0] t, tag; logic [32:0] r;
    for (int i = 0; i < 20; i++) begin
      a = rand_operand($urandom_range(0, 5)); b = rand_operand($urandom_range(0, 5));
      port = 1'($urandom_range(0, 1)); tag = 2'($urandom);
      r = ref_result(a, b);
      want_lat = r[32] ? 2 : N_ITER + 2;
      run_op(port, a, b, tag, lat, q, p, t, nl, ni);
      n_vec++; if (q !== r[31:0]) begin n_miss++; $display("[TB] FAIL rand%0d_quotient %h/%h got %h want %h", i, a, b, q, r[31:0]); end
      n_vec++; if (lat != want_lat) begin n_miss++; $display("[TB] FAIL rand%0d_latency got %0d want %0d", i, lat, want_lat); end
      n_vec++; if (p !== port || t !== tag) begin n_miss++; $display("[TB] FAIL rand%0d_port_tag got %b/%0d want %b/%0d", i, p, t, port, tag); end
      n_vec++; if (nl != (r[32] ? 0 : 1)) begin n_miss++; $display("[TB] FAIL rand%0d_load_count got %0d want %0d", i, nl, r[32] ? 0 : 1); end
    end
  endtask

  task automatic test_back_to_back();
    op_t p0 [2]; op_t p1 [2]; op_t acc_q [$]; bit grants [$];
    int i0, i1, nresp, both_rdy; bit adv0, adv1, g0; logic [32:0] r;
    for (int k = 0; k < 2; k++) begin
      p0[k] = '{a: rand_operand(3), b: rand_operand(3), tag: 2'(2 * k)};
      p1[k] = '{a: rand_operand(3), b: rand_operand(3), tag: 2'(2 * k + 1)};
    end
    i0 = 0; i1 = 0; nresp = 0; both_rdy = 0; adv0 = 1'b0; adv1 = 1'b0; g0 = model_ptr;
    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.in0_valid = 1'b1; bus.in0_dividend = p0[0].a; bus.in0_divisor = p0[0].b; bus.in0_tag = p0[0].tag;
    bus.in1_valid = 1'b1; bus.in1_dividend = p1[0].a; bus.in1_divisor = p1[0].b; bus.in1_tag = p1[0].tag;
    for (int c = 0; c < 300 && nresp < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (adv0) begin
        adv0 = 1'b0; i0++;
        if (i0 < 2) begin bus.in0_dividend = p0[i0].a; bus.in0_divisor = p0[i0].b; bus.in0_tag = p0[i0].tag; end
        else bus.in0_valid = 1'b0;
      end
      if (adv1) begin
        adv1 = 1'b0; i1++;
        if (i1 < 2) begin bus.in1_dividend = p1[i1].a; bus.in1_divisor = p1[i1].b; bus.in1_tag = p1[i1].tag; end
        else bus.in1_valid = 1'b0;
      end
      #1;
      if (bus.in0_ready && bus.in1_ready) both_rdy++;
      if (bus.in0_ready && bus.in0_valid) begin acc_q.push_back(p0[i0]); grants.push_back(1'b0); adv0 = 1'b1; end
      else if (bus.in1_ready && bus.in1_valid) begin acc_q.push_back(p1[i1]); grants.push_back(1'b1); adv1 = 1'b1; end
      if (bus.resp_valid && nresp < acc_q.size()) begin
        r = ref_result(acc_q[nresp].a, acc_q[nresp].b);
        n_vec++; if (bus.resp_quotient !== r[31:0]) begin n_miss++; $display("[TB] FAIL b2b%0d_quotient got %h want %h", nresp, bus.resp_quotient, r[31:0]); end
        n_vec++; if (bus.resp_tag !== acc_q[nresp].tag) begin n_miss++; $display("[TB] FAIL b2b%0d_tag got %0d want %0d", nresp, bus.resp_tag, acc_q[nresp].tag); end
        n_vec++; if (bus.resp_port !== grants[nresp]) begin n_miss++; $display("[TB] FAIL b2b%0d_port got %b want %b", nresp, bus.resp_port, grants[nresp]); end
        nresp++;
      end
    end
    @(negedge clk);
    bus.resp_ready = 1'b0; bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    n_vec++; if (nresp != 4) begin n_miss++; $display("[TB] FAIL b2b_resp_count got %0d want 4", nresp); end
    n_vec++; if (both_rdy != 0) begin n_miss++; $display("[TB] FAIL b2b_dual_ready got %0d cycles want 0", both_rdy); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (k >= grants.size() || grants[k] !== (g0 ^ k[0])) begin
        n_miss++; $display("[TB] FAIL b2b_grant%0d got %0d want %0d", k, (k < grants.size()) ? int'(grants[k]) : -1, g0 ^ k[0]);
      end
    end
    if (grants.size() > 0) model_ptr = !grants[grants.size() - 1];
  endtask

  task automatic test_backpressure();
    int errs, busy_rdy, t0; bit seen; logic [31:0] q0; bit p0; logic [1:0] tg0;
    errs = 0; busy_rdy = 0;
    @(negedge clk);
    bus.in0_valid = 1'b1; bus.in0_dividend = 32'h7F80_0000; bus.in0_divisor = 32'hC000_0000; bus.in0_tag = 2'd3;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin #1; if (bus.in0_ready) begin seen = 1'b1; break; end @(negedge clk); end
    n_vec++; if (!seen) begin n_miss++; $display("[TB] FAIL bp_accept got no ready want ready"); end
    model_ptr = 1'b1;
    @(negedge clk);
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b1; bus.in1_dividend = 32'h40C0_0000; bus.in1_divisor = 32'h4000_0000; bus.in1_tag = 2'd2;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.in1_ready) busy_rdy++;
      if (bus.resp_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    q0 = bus.resp_quotient; p0 = bus.resp_port; tg0 = bus.resp_tag;
    n_vec++; if (!seen || q0 !== 32'hFF80_0000 || p0 !== 1'b0 || tg0 !== 2'd3) begin n_miss++; $display("[TB] FAIL bp_resp got v=%b %h/%b/%0d want 1 ff800000/0/3", seen, q0, p0, tg0); end
    repeat (5) begin
      @(negedge clk); #1;
      if (!bus.resp_valid || bus.resp_quotient !== q0 || bus.resp_port !== p0 || bus.resp_tag !== tg0) errs++;
      if (bus.in0_ready || bus.in1_ready) busy_rdy++;
    end
    n_vec++; if (errs != 0) begin n_miss++; $display("[TB] FAIL bp_stable got %0d unstable cycles want 0", errs); end
    bus.resp_ready = 1'b1;
    #1;
    if (bus.in1_ready) busy_rdy++;
    n_vec++; if (busy_rdy != 0) begin n_miss++; $display("[TB] FAIL bp_held_off got %0d ready cycles want 0", busy_rdy); end
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    n_vec++; if (bus.in1_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL bp_pending_ready got %b want 1", bus.in1_ready); end
    t0 = ncyc; model_ptr = 1'b0;
    @(negedge clk);
    bus.in1_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin #1; if (bus.resp_valid) begin seen = 1'b1; break; end @(negedge clk); end
    n_vec++; if (!seen || ncyc - t0 != N_ITER + 2) begin n_miss++; $display("[TB] FAIL bp_pending_latency got %0d want %0d", seen ? ncyc - t0 : -1, N_ITER + 2); end
    n_vec++; if (bus.resp_quotient !== 32'h4040_0000 || bus.resp_port !== 1'b1 || bus.resp_tag !== 2'd2) begin n_miss++; $display("[TB] FAIL bp_pending_resp got %h/%b/%0d want 40400000/1/2", bus.resp_quotient, bus.resp_port, bus.resp_tag); end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, nl, ni, spurious; bit seen; logic [31:0] q; bit p; logic [1:0] t;
    @(negedge clk);
    bus.in0_valid = 1'b1; bus.in0_dividend = 32'h4120_0000; bus.in0_divisor = 32'h4080_0000; bus.in0_tag = 2'd3;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin #1; if (bus.in0_ready) begin seen = 1'b1; break; end @(negedge clk); end
    @(negedge clk);
    bus.in0_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (bus.core_iter_en && iter_in_op == 7) begin seen = 1'b1; break; end
      seen = 1'b0;
      @(negedge clk);
    end
    n_vec++; if (!seen) begin n_miss++; $display("[TB] FAIL rstmid_reach_iter7 got no 7th iteration want one"); end
    bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
    rst = 1'b0;
    #1;
    n_vec++; if (bus.resp_valid !== 1'b0 || bus.core_load !== 1'b0 || bus.core_iter_en !== 1'b0) begin n_miss++; $display("[TB] FAIL rstmid_ctrl got v=%b ld=%b it=%b want 000", bus.resp_valid, bus.core_load, bus.core_iter_en); end
    n_vec++; if (bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL rstmid_ready got %b%b want 00", bus.in0_ready, bus.in1_ready); end
    n_vec++; if (bus.resp_quotient !== 32'd0 || bus.resp_tag !== 2'd0 || bus.resp_port !== 1'b0) begin n_miss++; $display("[TB] FAIL rstmid_resp got %h/%0d/%b want 0/0/0", bus.resp_quotient, bus.resp_tag, bus.resp_port); end
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    model_ptr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    spurious = 0;
    repeat (30) begin @(negedge clk); #1; if (bus.resp_valid || bus.core_load || bus.core_iter_en) spurious++; end
    n_vec++; if (spurious != 0) begin n_miss++; $display("[TB] FAIL rstmid_aborted got %0d active cycles want 0", spurious); end
    run_op(1'b1, 32'h40C0_0000, 32'h4000_0000, 2'd2, lat, q, p, t, nl, ni);
    n_vec++; if (lat != N_ITER + 2 || q !== 32'h4040_0000) begin n_miss++; $display("[TB] FAIL rstmid_next_op got lat=%0d q=%h want %0d 40400000", lat, q, N_ITER + 2); end
    n_vec++; if (p !== 1'b1 || t !== 2'd2) begin n_miss++; $display("[TB] FAIL rstmid_next_port_tag got %b/%0d want 1/2", p, t); end
  endtask

  task automatic test_core_protocol();
    n_vec++; if (overlap_total != 0) begin n_miss++; $display("[TB] FAIL core_load_iter_overlap got %0d cycles want 0", overlap_total); end
    n_vec++; if (stab_err != 0) begin n_miss++; $display("[TB] FAIL core_operand_stability got %0d changes want 0", stab_err); end
  endtask

  initial begin
    bus.resp_ready = 1'b0;
    test_reset();
    test_basic();
    test_special();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_core_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
